// File: rtl/coreuart_host_ctrl.sv
// coreuart_host_ctrl
// Host-side front end for a CoreUART instance. Transmit bytes arrive on a
// valid/ready stream and become single-cycle UART writes. Received bytes are
// drained on RXRDY into a 2-entry buffer together with their parity and
// framing status. A single FSM owns the shared chip-select, and an 8-bit
// saturating counter records OVERFLOW rising edges.
module coreuart_host_ctrl #(
    parameter int unsigned GUARD_CYCLES = 3
) (
    input  logic       CLK,
    input  logic       RESET_N,

    // transmit stream
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,

    // receive stream
    output logic [7:0] rx_data,
    output logic       rx_perr,
    output logic       rx_ferr,
    output logic       rx_valid,
    input  logic       rx_ready,

    // overflow statistics
    output logic [7:0] ovf_cnt,
    input  logic       ovf_clr,

    // CoreUART strobe interface
    output logic       CSN,
    output logic       WEN,
    output logic       OEN,
    output logic [7:0] DATA_IN,
    input  logic [7:0] DATA_OUT,
    input  logic       TXRDY,
    input  logic       RXRDY,
    input  logic       PARITY_ERR,
    input  logic       FRAMING_ERR,
    input  logic       OVERFLOW
);

    // The guard counter only has to hold GUARD_CYCLES-1; keep it at least 1 bit wide.
    localparam int unsigned GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        GUARD = 2'd3
    } state_t;

    state_t         state;
    logic [GW-1:0]  guard_cnt;

    // rx buffer storage: {framing, parity, data} per entry
    logic [9:0]     buf_mem [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     buf_count;

    logic           buf_has_room;
    logic           rd_go;
    logic           wr_go;
    logic           push;
    logic           pop;
    logic [9:0]     head;

    logic           ovf_prev;
    logic           ovf_edge;

    // Arbitration decisions taken in IDLE; receive always wins over transmit
    // so that the UART receive holding register is drained promptly.
    always_comb begin
        buf_has_room = (buf_count != 2'd2);
        rd_go        = (state == IDLE) && RXRDY && buf_has_room;
        wr_go        = (state == IDLE) && !rd_go && tx_valid && TXRDY;
        tx_ready     = RESET_N && wr_go;
    end

    // Access sequencer: IDLE -> (WR | RD) -> GUARD -> IDLE, with registered strobes.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state     <= IDLE;
            guard_cnt <= '0;
            CSN       <= 1'b1;
            WEN       <= 1'b1;
            OEN       <= 1'b1;
            DATA_IN   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_go) begin
                        state <= RD;
                        CSN   <= 1'b0;
                        OEN   <= 1'b0;
                        WEN   <= 1'b1;
                    end else if (wr_go) begin
                        state   <= WR;
                        CSN     <= 1'b0;
                        WEN     <= 1'b0;
                        OEN     <= 1'b1;
                        DATA_IN <= tx_data;
                    end else begin
                        CSN <= 1'b1;
                        WEN <= 1'b1;
                        OEN <= 1'b1;
                    end
                end
                WR, RD: begin
                    state     <= GUARD;
                    guard_cnt <= GUARD_LOAD;
                    CSN       <= 1'b1;
                    WEN       <= 1'b1;
                    OEN       <= 1'b1;
                end
                GUARD: begin
                    CSN <= 1'b1;
                    WEN <= 1'b1;
                    OEN <= 1'b1;
                    if (guard_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        guard_cnt <= guard_cnt - GW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    CSN   <= 1'b1;
                    WEN   <= 1'b1;
                    OEN   <= 1'b1;
                end
            endcase
        end
    end

    // The byte is captured at the end of the RD cycle, when DATA_OUT is valid.
    always_comb begin
        push = (state == RD);
        pop  = rx_ready && (buf_count != 2'd0);
        head = buf_mem[rd_ptr];
    end

    // Two-entry circular rx buffer; simultaneous push and pop keeps the count.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            buf_count  <= 2'd0;
        end else begin
            if (push) begin
                buf_mem[wr_ptr] <= {FRAMING_ERR, PARITY_ERR, DATA_OUT};
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   buf_count <= buf_count + 2'd1;
                2'b01:   buf_count <= buf_count - 2'd1;
                default: buf_count <= buf_count;
            endcase
        end
    end

    // Head-of-buffer view; fields read as zero while the buffer is empty.
    always_comb begin
        rx_valid = (buf_count != 2'd0);
        rx_data  = rx_valid ? head[7:0] : 8'h00;
        rx_perr  = rx_valid ? head[8]   : 1'b0;
        rx_ferr  = rx_valid ? head[9]   : 1'b0;
    end

    assign ovf_edge = OVERFLOW && !ovf_prev;

    // Saturating count of OVERFLOW rising edges; a clear beats a coincident edge.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ovf_prev <= 1'b0;
            ovf_cnt  <= 8'h00;
        end else begin
            ovf_prev <= OVERFLOW;
            if (ovf_clr) begin
                ovf_cnt <= 8'h00;
            end else if (ovf_edge && (ovf_cnt != 8'hFF)) begin
                ovf_cnt <= ovf_cnt + 8'h01;
            end
        end
    end

endmodule

// File: tb/tb_coreuart_host_ctrl.sv
// tb_coreuart_host_ctrl
// Randomized bench for coreuart_host_ctrl. A transaction-level model predicts
// when the controller is free to start a UART access, which access it starts,
// the contents of the receive buffer as a queue, and the overflow count as a
// clamped integer; every cycle the DUT outputs are compared against it.
module tb_coreuart_host_ctrl;

    localparam int unsigned G = 3;

    logic       clk;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_perr;
    logic       rx_ferr;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] ovf_cnt;
    logic       ovf_clr;
    logic       csn;
    logic       wen;
    logic       oen;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       txrdy;
    logic       rxrdy;
    logic       parity_err;
    logic       framing_err;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    // model state
    logic [9:0] exp_q[$];
    int         acc_kind;      // access performed in the current cycle: 0 none, 1 write, 2 read
    longint     free_at;       // first cycle at which a new access may be chosen
    longint     cyc;
    logic [7:0] exp_data_in;
    int         exp_ovf;
    logic       exp_ovf_prev;
    bit         model_ready;

    coreuart_host_ctrl #(.GUARD_CYCLES(G)) dut (
        .CLK         (clk),
        .RESET_N     (reset_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_perr     (rx_perr),
        .rx_ferr     (rx_ferr),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .ovf_cnt     (ovf_cnt),
        .ovf_clr     (ovf_clr),
        .CSN         (csn),
        .WEN         (wen),
        .OEN         (oen),
        .DATA_IN     (data_in),
        .DATA_OUT    (data_out),
        .TXRDY       (txrdy),
        .RXRDY       (rxrdy),
        .PARITY_ERR  (parity_err),
        .FRAMING_ERR (framing_err),
        .OVERFLOW    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", tag, cyc, actual, expected);
        end
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic compareAll();
        bit         idle_now;
        bit         exp_tx_ready;
        logic [9:0] head;
        idle_now     = (acc_kind == 0) && (cyc >= free_at);
        exp_tx_ready = reset_n && idle_now && !(rxrdy && exp_q.size() < 2) && tx_valid && txrdy;
        head         = (exp_q.size() > 0) ? exp_q[0] : 10'h000;
        checkOutput("tx_ready", 32'(tx_ready), 32'(exp_tx_ready));
        checkOutput("CSN", 32'(csn), 32'(acc_kind == 0));
        checkOutput("WEN", 32'(wen), 32'(acc_kind != 1));
        checkOutput("OEN", 32'(oen), 32'(acc_kind != 2));
        checkOutput("wen_oen_excl", 32'(wen | oen), 32'd1);
        checkOutput("DATA_IN", 32'(data_in), 32'(exp_data_in));
        checkOutput("rx_valid", 32'(rx_valid), 32'(exp_q.size() > 0));
        checkOutput("rx_data", 32'(rx_data), 32'(head[7:0]));
        checkOutput("rx_perr", 32'(rx_perr), 32'(head[8]));
        checkOutput("rx_ferr", 32'(rx_ferr), 32'(head[9]));
        checkOutput("ovf_cnt", 32'(ovf_cnt), 32'(exp_ovf));
    endtask

    // Advance the model across one rising edge using this cycle's inputs.
    task automatic modelStep();
        int  size_pre;
        bit  idle_now;
        int  next_kind;
        size_pre = exp_q.size();
        idle_now = (acc_kind == 0) && (cyc >= free_at);
        if (!reset_n) begin
            exp_q.delete();
            acc_kind     = 0;
            free_at      = cyc + 1;
            exp_data_in  = 8'h00;
            exp_ovf      = 0;
            exp_ovf_prev = 1'b0;
            model_ready  = 1'b1;
        end else begin
            if (rx_ready && size_pre > 0) void'(exp_q.pop_front());
            if (acc_kind == 2) exp_q.push_back({framing_err, parity_err, data_out});
            next_kind = 0;
            if (idle_now && rxrdy && size_pre < 2) begin
                next_kind = 2;
                free_at   = cyc + 2 + G;
            end else if (idle_now && tx_valid && txrdy) begin
                next_kind   = 1;
                exp_data_in = tx_data;
                free_at     = cyc + 2 + G;
            end
            acc_kind = next_kind;
            if (ovf_clr) exp_ovf = 0;
            else if (overflow && !exp_ovf_prev && exp_ovf < 255) exp_ovf++;
            exp_ovf_prev = overflow;
        end
        cyc++;
    endtask

    // Drive one cycle of inputs for the given phase, check, then clock the model.
    // phase 0: reset with requests pending; 1: general random;
    // 2: steady OVERFLOW pulse train; 3: random with frequent clears
    task automatic applyStimulus(input int phase);
        @(negedge clk);
        tx_data     = 8'($urandom);
        data_out    = 8'($urandom);
        parity_err  = 1'($urandom);
        framing_err = 1'($urandom);
        txrdy       = ($urandom_range(99) < 70);
        rx_ready    = ($urandom_range(99) < 30);
        case (phase)
            0: begin
                reset_n  = 1'b0;
                tx_valid = 1'b1;
                rxrdy    = 1'b1;
                overflow = 1'($urandom);
                ovf_clr  = 1'b0;
            end
            2: begin
                reset_n  = 1'b1;
                tx_valid = 1'($urandom);
                rxrdy    = ($urandom_range(99) < 30);
                overflow = ~overflow;
                ovf_clr  = 1'b0;
            end
            3: begin
                reset_n  = 1'b1;
                tx_valid = 1'($urandom);
                rxrdy    = ($urandom_range(99) < 30);
                overflow = 1'($urandom);
                ovf_clr  = ($urandom_range(99) < 25);
            end
            default: begin
                reset_n  = ($urandom_range(299) != 0);
                tx_valid = ($urandom_range(99) < 50);
                rxrdy    = ($urandom_range(99) < 30);
                overflow = ($urandom_range(99) < 20);
                ovf_clr  = ($urandom_range(199) == 0);
            end
        endcase
        #1;
        if (model_ready) compareAll();
        @(posedge clk);
        modelStep();
    endtask

    initial begin
        reset_n     = 1'b0;
        tx_data     = 8'h00;
        tx_valid    = 1'b0;
        rx_ready    = 1'b0;
        ovf_clr     = 1'b0;
        data_out    = 8'h00;
        txrdy       = 1'b0;
        rxrdy       = 1'b0;
        parity_err  = 1'b0;
        framing_err = 1'b0;
        overflow    = 1'b0;
        acc_kind    = 0;
        free_at     = 0;
        cyc         = 0;
        exp_data_in = 8'h00;
        exp_ovf     = 0;
        exp_ovf_prev = 1'b0;
        model_ready = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus(0);
        for (int i = 0; i < 3000; i++) applyStimulus(1);
        for (int i = 0; i < 700; i++) applyStimulus(2);
        for (int i = 0; i < 1000; i++) applyStimulus(3);
        for (int i = 0; i < 3; i++) applyStimulus(0);
        for (int i = 0; i < 2000; i++) applyStimulus(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
